// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between a UART receiver/consumer and the receive FIFO.
// The master side drives received bytes and read requests; the slave side is the FIFO.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_data;
    logic          rx_done;
    logic          rd_en;
    logic          ovf_clr;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output rx_data, rx_done, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_done, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO behind a UART receiver: edge-detects rx_done into single writes,
// serves registered reads, and records dropped bytes in a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          rx_done_q;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          overflow;

    logic empty, full, wr_req, rd_acc, wr_acc, drop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign wr_req = bus.rx_done & ~rx_done_q;
    assign rd_acc = bus.rd_en & ~empty;
    // A read in the same cycle frees the slot the write lands in, so a full FIFO still accepts.
    assign wr_acc = wr_req & (~full | rd_acc);
    assign drop   = wr_req & full & ~rd_acc;

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_done_q <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            overflow  <= 1'b0;
        end else begin
            rx_done_q <= bus.rx_done;
            rd_valid  <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new drop wins over a clear in the same cycle.
            if (drop)             overflow <= 1'b1;
            else if (bus.ovf_clr) overflow <= 1'b0;
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count;
    assign bus.overflow = overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with DEPTH=8; inputs change 1 time unit after
// each rising edge and outputs are sampled at that same point.
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        step();
        bus.rx_done = 1'b0;
        step();
    endtask

    task automatic test_reset();
        bus.rx_data = 8'h00; bus.rx_done = 1'b0; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
        n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
        n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h exp 00", bus.rd_data); end
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
        for (int i = 0; i < 3; i++) write_byte(exp_b[i]);
        n_checks++; if (bus.count !== CW'(3)) begin n_fail++; $display("FAIL basic_count got %0d exp 3", bus.count); end
        n_checks++; if (bus.empty !== 1'b0) begin n_fail++; $display("FAIL basic_not_empty got %b exp 0", bus.empty); end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_b[i]) begin
                n_fail++; $display("FAIL basic_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp_b[i]);
            end
        end
        bus.rd_en = 1'b0;
        step();
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h43) begin
            n_fail++; $display("FAIL basic_hold got v=%b d=%h exp v=0 d=43", bus.rd_valid, bus.rd_data);
        end
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after got %b exp 1", bus.empty); end
    endtask

    task automatic test_latency();
        bus.rx_data = 8'hC3;
        bus.rx_done = 1'b1;
        step();
        n_checks++; if (bus.count !== CW'(1) || bus.empty !== 1'b0) begin
            n_fail++; $display("FAIL latency_count got c=%0d e=%b exp c=1 e=0", bus.count, bus.empty);
        end
        bus.rx_done = 1'b0;
        bus.rd_en = 1'b1;
        step();
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hC3) begin
            n_fail++; $display("FAIL latency_read got v=%b d=%h exp v=1 d=c3", bus.rd_valid, bus.rd_data);
        end
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_hold();
        bus.rx_data = 8'h55;
        bus.rx_done = 1'b1;
        for (int i = 0; i < 20; i++) step();
        bus.rx_done = 1'b0;
        step();
        n_checks++; if (bus.count !== CW'(1)) begin n_fail++; $display("FAIL hold_count got %0d exp 1", bus.count); end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        n_checks++; if (bus.rd_data !== 8'h55) begin n_fail++; $display("FAIL hold_data got %h exp 55", bus.rd_data); end
        step();
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) write_byte(8'h10 + 8'(i));
        n_checks++; if (bus.full !== 1'b1 || bus.count !== CW'(DEPTH) || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_state got f=%b c=%0d o=%b exp f=1 c=%0d o=1", bus.full, bus.count, bus.overflow, DEPTH);
        end
        // drop and clear in the same cycle: drop wins
        bus.rx_data = 8'hEE; bus.rx_done = 1'b1; bus.ovf_clr = 1'b1;
        step();
        n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_clr_vs_drop got %b exp 1", bus.overflow); end
        bus.rx_done = 1'b0;
        step();
        bus.ovf_clr = 1'b0;
        n_checks++; if (bus.overflow !== 1'b0 || bus.count !== CW'(DEPTH)) begin
            n_fail++; $display("FAIL ovf_clear got o=%b c=%0d exp o=0 c=%0d", bus.overflow, bus.count, DEPTH);
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL ovf_read%0d got v=%b d=%h exp v=1 d=%h", i, bus.rd_valid, bus.rd_data, 8'h10 + 8'(i));
            end
        end
        bus.rd_en = 1'b0;
        step();
        n_checks++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_drained got e=%b v=%b exp e=1 v=0", bus.empty, bus.rd_valid);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) write_byte(8'h20 + 8'(i));
        bus.rx_data = 8'hAA; bus.rx_done = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.rx_done = 1'b0;
        n_checks++; if (bus.count !== CW'(DEPTH) || bus.overflow !== 1'b0 || bus.rd_data !== 8'h20) begin
            n_fail++; $display("FAIL full_rw got c=%0d o=%b d=%h exp c=%0d o=0 d=20", bus.count, bus.overflow, bus.rd_data, DEPTH);
        end
        for (int i = 1; i < DEPTH; i++) begin
            step();
            n_checks++; if (bus.rd_data !== 8'h20 + 8'(i)) begin
                n_fail++; $display("FAIL full_rw_read%0d got %h exp %h", i, bus.rd_data, 8'h20 + 8'(i));
            end
        end
        step();
        bus.rd_en = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hAA) begin
            n_fail++; $display("FAIL full_rw_last got v=%b d=%h exp v=1 d=aa", bus.rd_valid, bus.rd_data);
        end
        step();
        n_checks++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL full_rw_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_empty_rw();
        bus.rx_data = 8'h7E; bus.rx_done = 1'b1; bus.rd_en = 1'b1;
        step();
        bus.rx_done = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.count !== CW'(1)) begin
            n_fail++; $display("FAIL empty_rw got v=%b c=%0d exp v=0 c=1", bus.rd_valid, bus.count);
        end
        step();
        bus.rd_en = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h7E) begin
            n_fail++; $display("FAIL empty_rw_read got v=%b d=%h exp v=1 d=7e", bus.rd_valid, bus.rd_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) write_byte(8'h30 + 8'(i));
        bus.rd_en = 1'b1;
        step(); step();
        bus.rx_data = 8'h66; bus.rx_done = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0; bus.rd_en = 1'b0;
        step();
        n_checks++; if (bus.count !== CW'(0) || bus.empty !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00) begin
            n_fail++; $display("FAIL rst_mid got c=%0d e=%b v=%b d=%h exp c=0 e=1 v=0 d=00", bus.count, bus.empty, bus.rd_valid, bus.rd_data);
        end
        step(); step();
        bus.rx_done = 1'b0;
        step();
        n_checks++; if (bus.count !== CW'(0)) begin n_fail++; $display("FAIL rst_held_done got %0d exp 0", bus.count); end
        write_byte(8'h99);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h99) begin
            n_fail++; $display("FAIL rst_first_read got v=%b d=%h exp v=1 d=99", bus.rd_valid, bus.rd_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_hold();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
